symbol_draw_scheduler: RTL and testbench
========================================

Name: symbol_draw_scheduler

Overview:
- Per-frame sequencer between the symbol program buffer and the drawing engine.
- On each frame-start strobe, snapshots the valid-symbol mask and walks slots 0..NUM_SYM-1 in ascending order.
- For each valid slot, fetches that slot's attributes through a synchronous read port and issues one draw job over a valid/ready handshake.
- Waits for the engine's done pulse before advancing to the next slot.

Parameters:
- NUM_SYM, 8, number of symbol slots (power of 2).
- SYM_ID_BITS, 3, log2(NUM_SYM).
- ATTR_BITS, 40, symbol attribute width (matches the program payload width).

Ports:
- i_clk  in  1  clock
- n_btn_rst  in  1  reset; asynchronous, active-low
- sched_en  in  1  when low, frame_start is ignored
- frame_start  in  1  one-cycle strobe (vsync-derived)
- valid_prog_idx  in  NUM_SYM  per-slot valid mask from the program buffer
- rd_idx  out  SYM_ID_BITS  buffer read address, combinational from the internal slot counter
- rd_data  in  ATTR_BITS  buffer read data, valid 1 cycle after rd_idx
- draw_valid  out  1  draw job offered
- draw_ready  in  1  engine accepts the job
- draw_sym_id  out  SYM_ID_BITS  slot ID of the offered job
- draw_attr  out  ATTR_BITS  attributes of the offered job
- draw_done  in  1  one-cycle pulse: engine finished the accepted job
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of the walk
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy
- sym_count  out  SYM_ID_BITS+1  symbols drawn in the current/last frame

Behaviour:
- Reset values: all outputs 0; state IDLE; slot counter 0; mask snapshot 0.
- Reset is asynchronous and takes effect mid-operation. Any offered job is dropped and no frame_done is issued.
- States: IDLE, SCAN, FETCH, ISSUE, WAIT_DONE, DONE.
- IDLE, on frame_start && sched_en:
  - mask <= valid_prog_idx
  - idx <= 0, sym_count <= 0
  - next state SCAN
- SCAN (one slot per cycle):
  - If mask[idx]: go to FETCH. rd_idx == idx this cycle.
  - Else if idx == NUM_SYM-1: go to DONE.
  - Else: idx <= idx+1.
- FETCH:
  - Latch draw_attr <= rd_data, draw_sym_id <= idx, draw_valid <= 1.
  - Next state ISSUE.
- ISSUE:
  - draw_valid, draw_attr and draw_sym_id stay stable until draw_ready is sampled high.
  - On handshake: draw_valid <= 0, go to WAIT_DONE.
- WAIT_DONE:
  - draw_done is sampled only in this state. A draw_done in any other state is ignored.
  - On draw_done: sym_count++. If idx == NUM_SYM-1, go to DONE; else idx++ and go to SCAN.
- DONE: frame_done = 1 for one cycle; next state IDLE.
- Latency:
  - frame_start sampled in cycle 0 → SCAN in cycle 1.
  - If slot 0 is valid: FETCH in cycle 2, draw_valid high in cycle 3.
  - Empty mask: frame_done in cycle NUM_SYM+1 (cycle 9 at the default NUM_SYM).
- Snapshot rule: changes to valid_prog_idx after the snapshot cycle do not affect the current frame. rd_data is re-read per slot, so attribute edits made before that slot's FETCH are visible.
- frame_start while busy:
  - Ignored for sequencing.
  - frame_overrun pulses in that same cycle (registered, visible the next cycle).
  - The current walk completes normally.
- sched_en falling mid-frame: the current walk completes; the next frame_start is ignored.
- frame_start together with DONE: treated as busy, so frame_overrun pulses and no restart occurs.
- sym_count: holds its value after DONE until the next accepted frame_start. Maximum is NUM_SYM, so it never wraps.

Decomposition:
- Package sym_sched_pkg:
  - state enum sched_state_t.
  - struct sym_attr_t: x[9:0], y[9:0], w[7:0], h[7:0], color[3:0], 40 bits total, which fixes ATTR_BITS.
  - Constants: NUM_SYM and SYM_ID_BITS.
- Single flat FSM module; no sub-module is warranted.

Test Plan:
- Mask 8'b0010_0101, frame_start, draw_ready tied 1, draw_done 2 cycles after each accept → jobs issued with IDs 0, 2, 5 in that order, each draw_attr equal to the buffer contents; frame_done pulses once; sym_count = 3.
- Mask 8'h00, frame_start at cycle 0 → draw_valid never asserted; frame_done exactly at cycle 9; sym_count = 0; busy high during cycles 1-9.
- Mask 8'h01, draw_ready held low for 5 cycles after draw_valid rises → draw_valid, draw_sym_id = 0 and draw_attr stay stable all 5 cycles; exactly one handshake occurs.
- Mask 8'hFF, second frame_start while in WAIT_DONE of slot 3 → frame_overrun pulses once; walk continues to slot 7; sym_count = 8; no restart.
- Mask 8'h81 at snapshot, then valid_prog_idx = 8'hFF one cycle later → only IDs 0 and 7 issued.
- n_btn_rst asserted while in ISSUE for slot 2 → draw_valid, busy and sym_count go to 0 immediately. After release, the next frame_start restarts the walk at slot 0.

Source files
------------

// File: rtl/sym_sched_pkg.sv
// Shared types and constants for the per-frame symbol draw scheduler.
`default_nettype none

package sym_sched_pkg;

  localparam int NUM_SYM     = 8;
  localparam int SYM_ID_BITS = 3;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] w;
    logic [7:0] h;
    logic [3:0] color;
  } sym_attr_t;

  localparam int ATTR_BITS = $bits(sym_attr_t);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_FETCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/symbol_draw_scheduler_if.sv
// Draw-job channel between the scheduler (master) and the drawing engine (slave).
`default_nettype none

interface symbol_draw_scheduler_if #(
  parameter int SYM_ID_BITS = sym_sched_pkg::SYM_ID_BITS,
  parameter int ATTR_BITS   = sym_sched_pkg::ATTR_BITS
) ();

  logic                   draw_valid;
  logic                   draw_ready;
  logic [SYM_ID_BITS-1:0] draw_sym_id;
  logic [ATTR_BITS-1:0]   draw_attr;
  logic                   draw_done;

  modport master (
    output draw_valid,
    output draw_sym_id,
    output draw_attr,
    input  draw_ready,
    input  draw_done
  );

  modport slave (
    input  draw_valid,
    input  draw_sym_id,
    input  draw_attr,
    output draw_ready,
    output draw_done
  );

endinterface

`default_nettype wire

// File: rtl/symbol_draw_scheduler.sv
// Walks the valid-symbol mask once per frame, fetching each slot's attributes
// and issuing one draw job per valid slot, waiting for completion before moving on.
`default_nettype none

module symbol_draw_scheduler #(
  parameter int NUM_SYM     = sym_sched_pkg::NUM_SYM,
  parameter int SYM_ID_BITS = sym_sched_pkg::SYM_ID_BITS,
  parameter int ATTR_BITS   = sym_sched_pkg::ATTR_BITS
) (
  input  wire logic                   i_clk,
  input  wire logic                   n_btn_rst,
  input  wire logic                   sched_en,
  input  wire logic                   frame_start,
  input  wire logic [NUM_SYM-1:0]     valid_prog_idx,
  output      logic [SYM_ID_BITS-1:0] rd_idx,
  input  wire logic [ATTR_BITS-1:0]   rd_data,
  symbol_draw_scheduler_if.master     draw_if,
  output      logic                   busy,
  output      logic                   frame_done,
  output      logic                   frame_overrun,
  output      logic [SYM_ID_BITS:0]   sym_count
);

  import sym_sched_pkg::*;

  localparam logic [SYM_ID_BITS-1:0] LAST_IDX = SYM_ID_BITS'(NUM_SYM - 1);

  sched_state_t           state_q,         state_d;
  logic [SYM_ID_BITS-1:0] idx_q,           idx_d;
  logic [NUM_SYM-1:0]     mask_q,          mask_d;
  logic [SYM_ID_BITS:0]   sym_count_q,     sym_count_d;
  logic                   draw_valid_q,    draw_valid_d;
  logic [SYM_ID_BITS-1:0] draw_sym_id_q,   draw_sym_id_d;
  logic [ATTR_BITS-1:0]   draw_attr_q,     draw_attr_d;
  logic                   frame_done_q,    frame_done_d;
  logic                   frame_overrun_q, frame_overrun_d;

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      mask_q          <= '0;
      sym_count_q     <= '0;
      draw_valid_q    <= 1'b0;
      draw_sym_id_q   <= '0;
      draw_attr_q     <= '0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      mask_q          <= mask_d;
      sym_count_q     <= sym_count_d;
      draw_valid_q    <= draw_valid_d;
      draw_sym_id_q   <= draw_sym_id_d;
      draw_attr_q     <= draw_attr_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    sym_count_d   = sym_count_q;
    draw_valid_d  = draw_valid_q;
    draw_sym_id_d = draw_sym_id_q;
    draw_attr_d   = draw_attr_q;
    frame_done_d  = 1'b0;
    // DONE counts as busy, so a strobe landing there is an overrun, not a restart
    frame_overrun_d = frame_start && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start && sched_en) begin
          mask_d      = valid_prog_idx;
          idx_d       = '0;
          sym_count_d = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mask_q[idx_q]) begin
          state_d = ST_FETCH;
        end else if (idx_q == LAST_IDX) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_FETCH: begin
        draw_attr_d   = rd_data;
        draw_sym_id_d = idx_q;
        draw_valid_d  = 1'b1;
        state_d       = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (draw_if.draw_ready) begin
          draw_valid_d = 1'b0;
          state_d      = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (draw_if.draw_done) begin
          sym_count_d = sym_count_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_idx              = idx_q;
  assign draw_if.draw_valid  = draw_valid_q;
  assign draw_if.draw_sym_id = draw_sym_id_q;
  assign draw_if.draw_attr   = draw_attr_q;
  assign busy                = (state_q != ST_IDLE);
  assign frame_done          = frame_done_q;
  assign frame_overrun       = frame_overrun_q;
  assign sym_count           = sym_count_q;

endmodule

`default_nettype wire

// File: tb/tb_symbol_draw_scheduler.sv
// Directed bench for symbol_draw_scheduler with a transaction-level job model.
`default_nettype none

module tb_symbol_draw_scheduler;
  import sym_sched_pkg::*;

  logic        i_clk          = 1'b0;
  logic        n_btn_rst      = 1'b1;
  logic        sched_en       = 1'b0;
  logic        frame_start    = 1'b0;
  logic [7:0]  valid_prog_idx = 8'h00;
  logic [2:0]  rd_idx;
  logic [39:0] rd_data        = '0;
  logic        draw_ready     = 1'b0;
  logic        draw_done      = 1'b0;
  logic        busy, frame_done, frame_overrun;
  logic [3:0]  sym_count;

  symbol_draw_scheduler_if #(.SYM_ID_BITS(3), .ATTR_BITS(40)) dif ();
  assign dif.draw_ready = draw_ready;
  assign dif.draw_done  = draw_done;

  symbol_draw_scheduler dut (
    .i_clk         (i_clk),
    .n_btn_rst     (n_btn_rst),
    .sched_en      (sched_en),
    .frame_start   (frame_start),
    .valid_prog_idx(valid_prog_idx),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .draw_if       (dif),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .sym_count     (sym_count)
  );

  always #5 i_clk = ~i_clk;

  // Program buffer: one-cycle synchronous read
  sym_attr_t mem [8];
  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i].x     = 10'(i * 37 + 5);
      mem[i].y     = 10'(i * 53 + 11);
      mem[i].w     = 8'(i * 17 + 3);
      mem[i].h     = 8'(i * 29 + 1);
      mem[i].color = 4'(i + 2);
    end
  end
  always @(posedge i_clk) rd_data <= mem[rd_idx];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: expected job order for the active frame
  int  exp_q[$];
  int  id_log[$];
  bit  frame_act  = 0;
  int  frame_jobs = 0;
  bit  ovr_exp    = 0;
  bit  prev_stall = 0;
  logic [2:0]  prev_id;
  logic [39:0] prev_attr;
  int  done_timer  = 0;
  int  jobs_seen   = 0;
  int  frames_seen = 0;
  int  ovr_seen    = 0;

  function automatic logic [23:0] pack_ids();
    logic [23:0] r = '0;
    for (int i = 0; i < id_log.size() && i < 8; i++) r[3*i +: 3] = id_log[i][2:0];
    return r;
  endfunction

  // Monitor at negedge; engine responds just after each posedge
  initial begin
    forever begin
      @(negedge i_clk);
      if (!n_btn_rst) begin
        exp_q.delete();
        frame_act  = 0;
        done_timer = 0;
        prev_stall = 0;
        ovr_exp    = 0;
        check("reset_outputs", {dif.draw_valid, busy, frame_done, frame_overrun, sym_count, dif.draw_attr},
              '0);
      end else begin
        check("overrun", frame_overrun, ovr_exp);
        if (frame_overrun) ovr_seen++;
        ovr_exp = frame_start && busy;
        if (prev_stall)
          check("hold_stable", {dif.draw_valid, dif.draw_sym_id, dif.draw_attr}, {1'b1, prev_id, prev_attr});
        if (dif.draw_valid && draw_ready) begin
          check("job_expected", (frame_act && exp_q.size() > 0), 1);
          if (frame_act && exp_q.size() > 0) begin
            check("job_id", dif.draw_sym_id, exp_q[0]);
            check("job_attr", dif.draw_attr, mem[exp_q[0]]);
            id_log.push_back(int'(dif.draw_sym_id));
            void'(exp_q.pop_front());
            jobs_seen++;
            done_timer = 2;
          end
        end
        prev_stall = dif.draw_valid && !draw_ready;
        prev_id    = dif.draw_sym_id;
        prev_attr  = dif.draw_attr;
        if (frame_done) begin
          frames_seen++;
          check("frame_done_legal", {frame_act, exp_q.size() == 0}, 2'b11);
          check("sym_count_at_done", sym_count, frame_jobs);
          frame_act = 0;
        end
        if (frame_start && sched_en && !busy) begin
          frame_act  = 1;
          frame_jobs = 0;
          exp_q.delete();
          for (int i = 0; i < 8; i++)
            if (valid_prog_idx[i]) begin
              exp_q.push_back(i);
              frame_jobs++;
            end
        end
      end
      @(posedge i_clk);
      #1;
      draw_done = 1'b0;
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) draw_done = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [7:0] m);
    valid_prog_idx = m;
    frame_start    = 1'b1;
    tick(1);
    frame_start    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_jobs(input string name, input int target);
    int k = 0;
    while (jobs_seen < target && k < 200) begin
      tick(1);
      k++;
    end
    check(name, (jobs_seen >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] busy_bits;
    logic [11:0] done_bits;
    logic        any_valid;
    int          base_f, base_j, base_o, k;

    #1 n_btn_rst = 1'b0;
    tick(3);
    check("reset_state", {dif.draw_valid, dif.draw_sym_id, dif.draw_attr, busy, frame_done,
                          frame_overrun, sym_count, rd_idx}, '0);
    n_btn_rst  = 1'b1;
    sched_en   = 1'b1;
    draw_ready = 1'b1;
    tick(2);

    // Sparse mask: jobs 0, 2, 5
    base_f = frames_seen;
    id_log.delete();
    start_frame(8'h25);
    wait_idle("t1_idle", 100);
    check("t1_ids", pack_ids(), {15'd0, 3'd5, 3'd2, 3'd0});
    check("t1_njobs", id_log.size(), 3);
    check("t1_frames", frames_seen - base_f, 1);
    check("t1_sym_count", sym_count, 4'd3);
    tick(3);
    check("t1_sym_count_hold", sym_count, 4'd3);

    // Empty mask: cycle-exact busy and frame_done
    valid_prog_idx = 8'h00;
    frame_start    = 1'b1;
    any_valid      = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      busy_bits[c] = busy;
      done_bits[c] = frame_done;
      any_valid    = any_valid | dif.draw_valid;
      @(posedge i_clk);
      #1;
      frame_start = 1'b0;
    end
    check("t2_busy_cycles", busy_bits, 12'h3FE);
    check("t2_frame_done_cycle", done_bits, 12'h200);
    check("t2_no_valid", any_valid, 1'b0);
    check("t2_sym_count", sym_count, 4'd0);

    // Back-pressure hold on slot 0
    draw_ready = 1'b0;
    base_j = jobs_seen;
    start_frame(8'h01);
    k = 0;
    while (!dif.draw_valid && k < 20) begin
      tick(1);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      check("t3_hold", {dif.draw_valid, dif.draw_sym_id, dif.draw_attr},
            {1'b1, 3'd0, 10'd5, 10'd11, 8'd3, 8'd1, 4'd2});
      tick(1);
    end
    draw_ready = 1'b1;
    wait_idle("t3_idle", 50);
    check("t3_one_handshake", jobs_seen - base_j, 1);

    // Overrun while waiting on slot 3
    base_f = frames_seen;
    base_o = ovr_seen;
    base_j = jobs_seen;
    id_log.delete();
    start_frame(8'hFF);
    wait_jobs("t4_reach_slot3", base_j + 4);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_idle("t4_idle", 200);
    tick(2);
    check("t4_overruns", ovr_seen - base_o, 1);
    check("t4_ids", pack_ids(), {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    check("t4_sym_count", sym_count, 4'd8);
    check("t4_no_restart", {busy, 6'(frames_seen - base_f)}, {1'b0, 6'd1});

    // Mask snapshot ignores later edits
    id_log.delete();
    valid_prog_idx = 8'h81;
    frame_start    = 1'b1;
    tick(1);
    frame_start    = 1'b0;
    valid_prog_idx = 8'hFF;
    wait_idle("t5_idle", 100);
    check("t5_ids", pack_ids(), {18'd0, 3'd7, 3'd0});
    check("t5_njobs", id_log.size(), 2);

    // Scheduler disabled: strobe ignored
    sched_en = 1'b0;
    start_frame(8'hFF);
    tick(1);
    check("t7_disabled", busy, 1'b0);
    sched_en = 1'b1;

    // Async reset while slot 2 is being offered
    base_j = jobs_seen;
    start_frame(8'h07);
    wait_jobs("t6_reach_slot1", base_j + 2);
    draw_ready = 1'b0;
    k = 0;
    while (!dif.draw_valid && k < 30) begin
      tick(1);
      k++;
    end
    check("t6_issue_slot2", {dif.draw_valid, dif.draw_sym_id, sym_count}, {1'b1, 3'd2, 4'd2});
    #2 n_btn_rst = 1'b0;
    #1;
    check("t6_async_reset", {dif.draw_valid, busy, sym_count}, '0);
    tick(2);
    n_btn_rst  = 1'b1;
    draw_ready = 1'b1;
    tick(1);
    base_f = frames_seen;
    id_log.delete();
    start_frame(8'h07);
    wait_idle("t6_idle", 100);
    check("t6_restart_ids", pack_ids(), {15'd0, 3'd2, 3'd1, 3'd0});
    check("t6_restart_count", {sym_count, 4'(frames_seen - base_f)}, {4'd3, 4'd1});

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
